// File: rtl/i2c_target_ctrl_if.sv
// Bus-side (SCL/SDA) and core-side (rx/tx byte) signals of the I2C target.
// The slave modport is the target's view; the master modport is its environment's view.
interface i2c_target_ctrl_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;

  modport slave (
    input  scl_in, sda_in, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, busy
  );

  modport master (
    output scl_in, sda_in, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, busy
  );
endinterface

// File: rtl/i2c_target_ctrl.sv
// Oversampling I2C target: START/STOP detection, 7-bit address match, ACK, write strobes, read requests.
// Define I2C_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL and SDA (+2 clk latency).
module i2c_target_ctrl #(
  parameter logic [6:0] ADDR = 7'h27
) (
  input  logic             clk,
  input  logic             rst,
  i2c_target_ctrl_if.slave bus_if
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_WAIT_STOP
  } state_t;

  // Line 0 is SCL, line 1 is SDA; both idle high so reset values never look like an edge.
  logic [1:0] line_raw;
  logic [1:0] line_cur;
  logic [1:0] line_prev;

  assign line_raw = {bus_if.sda_in, bus_if.scl_in};

  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic sync1_q;
    logic sync2_q;
    logic prev_q;
`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hist_q <= 2'b11;
        filt_q <= 1'b1;
      end else begin
        hist_q <= {hist_q[0], sync2_q};
        filt_q <= (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
      end
    end
    assign line_cur[gi] = filt_q;
`else
    assign line_cur[gi] = sync2_q;
`endif
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        prev_q  <= 1'b1;
      end else begin
        sync1_q <= line_raw[gi];
        sync2_q <= sync1_q;
        prev_q  <= line_cur[gi];
      end
    end
    assign line_prev[gi] = prev_q;
  end

  logic scl, sda, scl_rise, scl_fall, start_ev, stop_ev;
  assign scl      = line_cur[0];
  assign sda      = line_cur[1];
  assign scl_rise = scl & ~line_prev[0];
  assign scl_fall = ~scl & line_prev[0];
  assign start_ev = scl & line_prev[0] & line_prev[1] & ~sda;
  assign stop_ev  = scl & line_prev[0] & ~line_prev[1] & sda;

  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic       rw_q;
  logic       ack_phase_q;
  logic       nack_q;
  logic       sda_oe_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       tx_req_q;
  logic       busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      rw_q        <= 1'b0;
      ack_phase_q <= 1'b0;
      nack_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      if (start_ev) begin
        state_q     <= S_ADDR;
        bit_cnt_q   <= 3'd0;
        ack_phase_q <= 1'b0;
        sda_oe_q    <= 1'b0;
      end else if (stop_ev) begin
        state_q   <= S_IDLE;
        bit_cnt_q <= 3'd0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE, S_WAIT_STOP: sda_oe_q <= 1'b0;
          S_ADDR: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[5:0], sda};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                rw_q        <= sda;
                ack_phase_q <= 1'b0;
                if (shift_q == ADDR) begin
                  state_q <= S_ADDR_ACK;
                end else begin
                  state_q <= S_WAIT_STOP;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase_q) begin
                sda_oe_q    <= 1'b1;
                busy_q      <= 1'b1;
                ack_phase_q <= 1'b1;
              end else begin
                ack_phase_q <= 1'b0;
                if (rw_q) begin
                  // ACK stays driven one more cycle until bit 7 is loaded from tx_data.
                  tx_req_q  <= 1'b1;
                  bit_cnt_q <= 3'd0;
                  state_q   <= S_READ;
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= S_WRITE;
                end
              end
            end
          end
          S_WRITE: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[5:0], sda};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                rx_data_q   <= {shift_q, sda};
                rx_valid_q  <= 1'b1;
                ack_phase_q <= 1'b0;
                state_q     <= S_WRITE_ACK;
              end
            end
          end
          S_WRITE_ACK: begin
            if (scl_fall) begin
              sda_oe_q    <= ~ack_phase_q;
              ack_phase_q <= ~ack_phase_q;
              if (ack_phase_q) state_q <= S_WRITE;
            end
          end
          S_READ: begin
            if (tx_req_q) begin
              shift_q   <= bus_if.tx_data[6:0];
              sda_oe_q  <= ~bus_if.tx_data[7];
              bit_cnt_q <= 3'd0;
            end else if (scl_fall) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                sda_oe_q <= 1'b0;
                state_q  <= S_READ_ACK;
              end else begin
                sda_oe_q <= ~shift_q[6];
                shift_q  <= {shift_q[5:0], 1'b0};
              end
            end
          end
          S_READ_ACK: begin
            if (scl_rise) begin
              nack_q <= sda;
            end else if (scl_fall) begin
              if (nack_q) begin
                state_q <= S_WAIT_STOP;
              end else begin
                tx_req_q <= 1'b1;
                state_q  <= S_READ;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus_if.sda_oe   = sda_oe_q;
  assign bus_if.rx_data  = rx_data_q;
  assign bus_if.rx_valid = rx_valid_q;
  assign bus_if.tx_req   = tx_req_q;
  assign bus_if.busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_ctrl.sv
// Bench for i2c_target_ctrl: a bit-banged I2C master on a wired-AND SDA line, a transaction-level
// expectation model (queues of expected write bytes, known read bytes) and a per-cycle output monitor.
module tb_i2c_target_ctrl;
  localparam int Q = 5;  // clocks per quarter SCL period (SCL = 20 clk)

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic [7:0] tx_data_m;

  int checks   = 0;
  int failures = 0;
  int rx_cnt   = 0;
  int tx_cnt   = 0;
  int oe_cnt   = 0;

  logic [7:0] exp_rx_q[$];

  i2c_target_ctrl_if bus_if ();
  assign bus_if.scl_in  = scl_m;
  assign bus_if.sda_in  = sda_m & ~bus_if.sda_oe;
  assign bus_if.tx_data = tx_data_m;

  i2c_target_ctrl #(.ADDR(7'h27)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle monitor: strobe widths, write bytes against the expected queue, SDA drive legality.
  logic prev_oe  = 1'b0;
  logic prev_rxv = 1'b0;
  logic prev_txr = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_oe  = 1'b0;
      prev_rxv = 1'b0;
      prev_txr = 1'b0;
    end else begin
      if (bus_if.sda_oe !== prev_oe) begin
        if (bus_if.sda_oe === 1'b1) begin
          oe_cnt++;
          check("oe_assert_while_scl_low", 32'(scl_m), 32'd0);
        end
      end
      if (bus_if.rx_valid) begin
        check("rx_valid_width", 32'(prev_rxv), 32'd0);
        rx_cnt++;
        if (exp_rx_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected: rx_data=0x%0h strobed with no byte expected", bus_if.rx_data);
        end else begin
          check("rx_data", 32'(bus_if.rx_data), 32'(exp_rx_q.pop_front()));
        end
      end
      if (bus_if.tx_req) begin
        check("tx_req_width", 32'(prev_txr), 32'd0);
        tx_cnt++;
      end
      prev_oe  = bus_if.sda_oe;
      prev_rxv = bus_if.rx_valid;
      prev_txr = bus_if.tx_req;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic sampled);
    sda_m = b;
    wq();
    scl_m = 1'b1;
    wq();
    sampled = bus_if.sda_in;
    wq();
    scl_m = 1'b0;
    wq();
  endtask

  task automatic start_cond();
    sda_m = 1'b1;
    wq();
    scl_m = 1'b1;
    wq();
    sda_m = 1'b0;
    wq();
    scl_m = 1'b0;
    wq();
  endtask

  task automatic stop_cond();
    sda_m = 1'b0;
    wq();
    scl_m = 1'b1;
    wq();
    sda_m = 1'b1;
    wq();
    wq();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  // Reads one byte; the next tx_data is presented during the ACK clock, before its falling edge.
  task automatic rbyte(input logic master_ack, input logic [7:0] next_tx, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    sda_m = ~master_ack;
    wq();
    scl_m = 1'b1;
    wq();
    tx_data_m = next_tx;
    wq();
    scl_m = 1'b0;
    wq();
  endtask

  logic       ack;
  logic       s_bit;
  logic [7:0] got;
  int         rx0, tx0, oe0;

  initial begin
    rst       = 1'b1;
    scl_m     = 1'b1;
    sda_m     = 1'b1;
    tx_data_m = 8'h00;
    repeat (4) @(negedge clk);
    check("reset_sda_oe", 32'(bus_if.sda_oe), 32'd0);
    check("reset_rx_data", 32'(bus_if.rx_data), 32'h00);
    check("reset_rx_valid", 32'(bus_if.rx_valid), 32'd0);
    check("reset_tx_req", 32'(bus_if.tx_req), 32'd0);
    check("reset_busy", 32'(bus_if.busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single-byte write.
    rx0 = rx_cnt;
    start_cond();
    wbyte(8'h4E, ack);
    check("wr_addr_ack", 32'(ack), 32'd0);
    check("wr_busy", 32'(bus_if.busy), 32'd1);
    exp_rx_q.push_back(8'hC3);
    wbyte(8'hC3, ack);
    check("wr_data_ack", 32'(ack), 32'd0);
    stop_cond();
    check("wr_rx_data", 32'(bus_if.rx_data), 32'hC3);
    check("wr_rx_pulses", 32'(rx_cnt - rx0), 32'd1);
    check("wr_busy_after_stop", 32'(bus_if.busy), 32'd0);

    // Address miss.
    rx0 = rx_cnt;
    oe0 = oe_cnt;
    start_cond();
    wbyte(8'h50, ack);
    check("miss_addr_nack", 32'(ack), 32'd1);
    check("miss_busy", 32'(bus_if.busy), 32'd0);
    wbyte(8'h11, ack);
    check("miss_data_nack", 32'(ack), 32'd1);
    stop_cond();
    check("miss_no_rx", 32'(rx_cnt - rx0), 32'd0);
    check("miss_no_oe", 32'(oe_cnt - oe0), 32'd0);
    check("miss_busy_end", 32'(bus_if.busy), 32'd0);

    // Single-byte read, master NACK.
    tx0 = tx_cnt;
    tx_data_m = 8'hA5;
    start_cond();
    wbyte(8'h4F, ack);
    check("rd_addr_ack", 32'(ack), 32'd0);
    rbyte(1'b0, 8'h00, got);
    check("rd_byte", 32'(got), 32'hA5);
    stop_cond();
    check("rd_tx_req_pulses", 32'(tx_cnt - tx0), 32'd1);
    check("rd_busy_end", 32'(bus_if.busy), 32'd0);

    // Two-byte read: ACK then NACK.
    tx0 = tx_cnt;
    tx_data_m = 8'h3C;
    start_cond();
    wbyte(8'h4F, ack);
    check("mrd_addr_ack", 32'(ack), 32'd0);
    rbyte(1'b1, 8'h81, got);
    check("mrd_byte0", 32'(got), 32'h3C);
    rbyte(1'b0, 8'h00, got);
    check("mrd_byte1", 32'(got), 32'h81);
    stop_cond();
    check("mrd_tx_req_pulses", 32'(tx_cnt - tx0), 32'd2);

    // Write then repeated START into a read.
    tx0 = tx_cnt;
    start_cond();
    wbyte(8'h4E, ack);
    check("rs_wr_addr_ack", 32'(ack), 32'd0);
    exp_rx_q.push_back(8'h12);
    wbyte(8'h12, ack);
    check("rs_wr_data_ack", 32'(ack), 32'd0);
    tx_data_m = 8'h5A;
    start_cond();
    wbyte(8'h4F, ack);
    check("rs_rd_addr_ack", 32'(ack), 32'd0);
    check("rs_rx_data", 32'(bus_if.rx_data), 32'h12);
    rbyte(1'b0, 8'h00, got);
    check("rs_rd_byte", 32'(got), 32'h5A);
    stop_cond();
    check("rs_tx_req_pulses", 32'(tx_cnt - tx0), 32'd1);

    // Reset in the middle of a read byte that drives SDA low on every bit.
    tx_data_m = 8'h00;
    start_cond();
    wbyte(8'h4F, ack);
    check("rst_addr_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bit_xfer(1'b1, s_bit);
      check("rst_rd_bit", 32'(s_bit), 32'd0);
    end
    check("rst_pre_oe", 32'(bus_if.sda_oe), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_oe_async", 32'(bus_if.sda_oe), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    stop_cond();
    start_cond();
    wbyte(8'h4E, ack);
    check("post_rst_addr_ack", 32'(ack), 32'd0);
    exp_rx_q.push_back(8'h77);
    wbyte(8'h77, ack);
    check("post_rst_data_ack", 32'(ack), 32'd0);
    stop_cond();
    check("post_rst_rx_data", 32'(bus_if.rx_data), 32'h77);

`ifdef I2C_GLITCH_FILTER_EN
    // A one-clock SCL pulse inside a low phase must not shift a bit.
    start_cond();
    wbyte(8'h4E, ack);
    check("glitch_addr_ack", 32'(ack), 32'd0);
    exp_rx_q.push_back(8'h96);
    got = 8'h96;
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) begin
        @(negedge clk);
        scl_m = 1'b1;
        @(negedge clk);
        scl_m = 1'b0;
      end
      bit_xfer(got[i], s_bit);
    end
    bit_xfer(1'b1, ack);
    check("glitch_data_ack", 32'(ack), 32'd0);
    stop_cond();
    check("glitch_rx_data", 32'(bus_if.rx_data), 32'h96);
`endif

    // Randomized transactions; the model decides ACKs, expected write bytes and read bytes.
    begin
      logic       open;
      logic [6:0] a;
      logic       rw;
      logic       hit;
      logic [7:0] d;
      logic [7:0] cur;
      logic [7:0] nxt;
      int         n;
      open = 1'b0;
      for (int t = 0; t < 30; t++) begin
        a   = ($urandom_range(3) == 0) ? 7'($urandom_range(127)) : 7'h27;
        rw  = 1'($urandom_range(1));
        n   = $urandom_range(1, 3);
        hit = (a == 7'h27);
        if (rw) tx_data_m = 8'($urandom);
        cur = tx_data_m;
        tx0 = tx_cnt;
        start_cond();
        wbyte({a, rw}, ack);
        check("rnd_addr_ack", 32'(ack), 32'(!hit));
        check("rnd_busy", 32'(bus_if.busy), 32'(hit));
        if (hit && !rw) begin
          for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            exp_rx_q.push_back(d);
            wbyte(d, ack);
            check("rnd_wr_ack", 32'(ack), 32'd0);
          end
        end else if (hit && rw) begin
          for (int i = 0; i < n; i++) begin
            nxt = 8'($urandom);
            rbyte(i != n - 1, nxt, got);
            check("rnd_rd_byte", 32'(got), 32'(cur));
            cur = nxt;
          end
          check("rnd_tx_req_pulses", 32'(tx_cnt - tx0), 32'(n));
        end
        open = ($urandom_range(2) == 0);
        if (!open) begin
          stop_cond();
          check("rnd_busy_after_stop", 32'(bus_if.busy), 32'd0);
        end
      end
      if (open) stop_cond();
    end

    repeat (10) @(negedge clk);
    check("rx_all_delivered", 32'(exp_rx_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
